// File: rtl/thirty_two_bit_comparator.sv
// thirty_two_bit_comparator: registered 32-bit magnitude compare built from eight nibble slices.
// Build option CMP_SIGNED_EN selects a two's-complement compare.
module thirty_two_bit_comparator (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        gt,
   output logic        eq,
   output logic        lt
);
   logic [7:0] sg;
   logic [7:0] sl;
   logic [1:0] u;
   logic [1:0] r;
   // {gt,lt} of a nibble; the first differing bit from the MSB yields {x,y} = 10 or 01
   function automatic logic [1:0] cmp4(input logic [3:0] x, input logic [3:0] y);
      logic [1:0] c;
      c = 2'b00;
      for (int i = 3; i >= 0; i--)
         if (c == 2'b00 && x[i] != y[i]) c = {x[i], y[i]};
      return c;
   endfunction
   for (genvar n = 0; n < 8; n++) begin : g_slice
      assign {sg[n], sl[n]} = cmp4(a[4*n+3:4*n], b[4*n+3:4*n]);
   end
   always_comb begin
      u = 2'b00;
      for (int i = 7; i >= 0; i--)
         if (u == 2'b00 && (sg[i] | sl[i])) u = {sg[i], sl[i]};
   end
`ifdef CMP_SIGNED_EN
   // differing sign bits: the non-negative operand is greater
   assign r = (a[31] != b[31]) ? {b[31], a[31]} : u;
`else
   assign r = u;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) {gt, eq, lt} <= 3'b000;
      else {gt, eq, lt} <= {r[1], r == 2'b00, r[0]};
endmodule

// File: tb/tb_thirty_two_bit_comparator.sv
// tb_thirty_two_bit_comparator: scoreboard bench for thirty_two_bit_comparator (unsigned or CMP_SIGNED_EN).
module tb_thirty_two_bit_comparator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] a = 32'd5;
   logic [31:0] b = 32'd3;
   logic gt, eq, lt;
   int total = 0;
   int bad = 0;
   typedef struct {logic [2:0] e; int id;} item_t;
   item_t q[$];
   item_t it;

   localparam logic [2:0] GT = 3'b100, EQ = 3'b010, LT = 3'b001;
`ifdef CMP_SIGNED_EN
   localparam logic [2:0] NEG_A = LT, NEG_B = GT;
`else
   localparam logic [2:0] NEG_A = GT, NEG_B = LT;
`endif
   logic [31:0] va [12] = '{32'h40000000, 32'h40000000, 32'h7F000182, 32'h7F000181,
                            32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000,
                            32'h7FFFFFFF, 32'h00000000, 32'h12345678, 32'h00010000};
   logic [31:0] vb [12] = '{32'h3FFFFFFF, 32'h7FFFFFFF, 32'h7F000184, 32'h7F000180,
                            32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00000000,
                            32'hFFFFFFFF, 32'h00000001, 32'h12345678, 32'h0000FFFF};
   logic [2:0]  ve [12] = '{GT, LT, LT, GT, EQ, EQ, NEG_A, NEG_A, NEG_B, LT, EQ, GT};

   always #5 clk = ~clk;

   thirty_two_bit_comparator dut (.clk(clk), .rst(rst), .a(a), .b(b), .gt(gt), .eq(eq), .lt(lt));

   function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y);
`ifdef CMP_SIGNED_EN
      return ($signed(x) > $signed(y)) ? GT : (x == y) ? EQ : LT;
`else
      return (x > y) ? GT : (x == y) ? EQ : LT;
`endif
   endfunction

   task automatic check(input string n, input logic [2:0] act, input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got gt/eq/lt=%b want %b", n, act, exp);
      end
   endtask

   task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [2:0] e, input int id);
      @(negedge clk);
      a = x;
      b = y;
      q.push_back('{e, id});
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst && q.size() > 0) begin
         it = q.pop_front();
         check($sformatf("vec%0d", it.id), {gt, eq, lt}, it.e);
      end
   end

   initial begin
      #2 check("rst_async", {gt, eq, lt}, 3'b000);
      repeat (2) @(posedge clk);
      #1 check("rst_held", {gt, eq, lt}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      q.push_back('{GT, 0});
      for (int i = 0; i < 12; i++) apply(va[i], vb[i], ve[i], 100 + i);
      @(negedge clk);
      a = 32'd1;
      b = 32'd2;
      #1 rst = 1'b1;
      #1 check("rst_mid_async", {gt, eq, lt}, 3'b000);
      @(posedge clk);
      #1 check("rst_mid_edge", {gt, eq, lt}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      q.push_back('{LT, 200});
      for (int i = 0; i < 10000; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         y = (i % 8 == 0) ? x : $urandom;
         apply(x, y, ref_cmp(x, y), 1000 + i);
      end
      repeat (3) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
